// File: rtl/serial_pkg.sv
// Shared types and helpers for the length-prefixed serial packet transmitter.
package serial_pkg;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PAY   = 3'd2,
        ST_STALL = 3'd3,
        ST_CSUM  = 3'd4
    } tx_state_t;

    // Level driven on the serial line whenever no frame bit is being sent
    localparam logic SER_IDLE_LVL = 1'b1;

    // Widest word the checksum helper handles
    localparam int CSUM_MAX_W = 64;

    // XOR checksum step; the result is masked to 'width' bits so callers of any
    // word width up to CSUM_MAX_W can share one helper.
    function automatic logic [CSUM_MAX_W-1:0] csum_xor(
        input logic [CSUM_MAX_W-1:0] acc,
        input logic [CSUM_MAX_W-1:0] word,
        input int unsigned           width
    );
        logic [CSUM_MAX_W-1:0] mask;
        mask = (width >= CSUM_MAX_W) ? '1
                                     : ((CSUM_MAX_W'(1) << width) - CSUM_MAX_W'(1));
        return (acc ^ word) & mask;
    endfunction

endpackage

// File: rtl/serial_shift_out.sv
// Parallel-load shift register presenting one bit per clock, in either bit order.
// Vacated positions fill with the line idle level, so an exhausted register reads 1.
module serial_shift_out
    import serial_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic              tClk,
    input  logic              Rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] Din,
    output logic              bit_out
);

    logic [WORD_W-1:0] sreg;

    // Load a new word or advance by one bit; load wins when both are requested
    always_ff @(posedge tClk or posedge Rst) begin
        if (Rst) begin
            sreg <= '1;
        end else if (load) begin
            sreg <= Din;
        end else if (shift) begin
            if (MSB_FIRST != 0) begin
                sreg <= {sreg[WORD_W-2:0], SER_IDLE_LVL};
            end else begin
                sreg <= {SER_IDLE_LVL, sreg[WORD_W-1:1]};
            end
        end
    end

    assign bit_out = (MSB_FIRST != 0) ? sreg[WORD_W-1] : sreg[0];

endmodule

// File: rtl/serial_packet_tx.sv
// Length-prefixed serial packet transmitter: header word L, then L payload words,
// then an optional XOR checksum word, one bit per clock. Stalls between words when
// the source runs dry, rejects over-long headers and pulses Done at frame end.
module serial_packet_tx
    import serial_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int MAX_LEN   = 255,
    parameter int MSB_FIRST = 0,
    parameter int CSUM_EN   = 1
) (
    input  logic              tClk,
    input  logic              Rst,
    input  logic [WORD_W-1:0] Din,
    input  logic              Din_Valid,
    output logic              Din_Ready,
    output logic              Dout,
    output logic              Dout_Valid,
    output logic              Busy,
    output logic              Done,
    output logic              Len_Err
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam int CNT_W = (MAX_LEN < 1) ? 1 : $clog2(MAX_LEN + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  remaining;
    logic [WORD_W-1:0] csum;

    logic              last_bit;
    logic              rem_nz;
    logic              len_ok;
    logic              sh_load;
    logic              sh_shift;
    logic              load_csum;
    logic              hdr_take;
    logic              pay_take;
    logic              frame_end;
    logic              len_reject;
    logic [WORD_W-1:0] sh_data;
    logic              bit_out;

    assign last_bit   = (bit_cnt == LAST_BIT);
    assign rem_nz     = (remaining != '0);
    assign len_ok     = (Din <= WORD_W'(MAX_LEN));
    assign sh_data    = load_csum ? csum : Din;
    assign Busy       = (state != ST_IDLE);
    assign Dout_Valid = (state == ST_HDR) || (state == ST_PAY) || (state == ST_CSUM);
    assign Dout       = Dout_Valid ? bit_out : SER_IDLE_LVL;

    // Next-state and handshake decode; Din_Ready depends on state only, never on Din_Valid
    always_comb begin
        state_nxt  = state;
        Din_Ready  = 1'b0;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        load_csum  = 1'b0;
        hdr_take   = 1'b0;
        pay_take   = 1'b0;
        frame_end  = 1'b0;
        len_reject = 1'b0;
        case (state)
            ST_IDLE: begin
                Din_Ready = 1'b1;
                if (Din_Valid) begin
                    if (len_ok) begin
                        hdr_take  = 1'b1;
                        sh_load   = 1'b1;
                        state_nxt = ST_HDR;
                    end else begin
                        len_reject = 1'b1;
                    end
                end
            end
            ST_HDR, ST_PAY: begin
                Din_Ready = last_bit && rem_nz;
                sh_shift  = 1'b1;
                if (last_bit) begin
                    if (rem_nz) begin
                        if (Din_Valid) begin
                            pay_take  = 1'b1;
                            sh_load   = 1'b1;
                            state_nxt = ST_PAY;
                        end else begin
                            state_nxt = ST_STALL;
                        end
                    end else if (CSUM_EN != 0) begin
                        load_csum = 1'b1;
                        sh_load   = 1'b1;
                        state_nxt = ST_CSUM;
                    end else begin
                        frame_end = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_STALL: begin
                Din_Ready = 1'b1;
                if (Din_Valid) begin
                    pay_take  = 1'b1;
                    sh_load   = 1'b1;
                    state_nxt = ST_PAY;
                end
            end
            ST_CSUM: begin
                sh_shift = 1'b1;
                if (last_bit) begin
                    frame_end = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge tClk or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit/word counters, running checksum and the one-cycle status pulses
    always_ff @(posedge tClk or posedge Rst) begin
        if (Rst) begin
            bit_cnt   <= '0;
            remaining <= '0;
            csum      <= '0;
            Done      <= 1'b0;
            Len_Err   <= 1'b0;
        end else begin
            Done    <= frame_end;
            Len_Err <= len_reject;
            if (sh_load) begin
                bit_cnt <= '0;
            end else if (sh_shift) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
            end
            if (hdr_take) begin
                csum      <= Din;
                remaining <= CNT_W'(Din);
            end else if (pay_take) begin
                csum      <= WORD_W'(csum_xor(CSUM_MAX_W'(csum), CSUM_MAX_W'(Din), WORD_W));
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    serial_shift_out #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .tClk    (tClk),
        .Rst     (Rst),
        .load    (sh_load),
        .shift   (sh_shift),
        .Din     (sh_data),
        .bit_out (bit_out)
    );

endmodule

// File: tb/tb_serial_packet_tx.sv
// Self-checking bench for serial_packet_tx: three instances with different bit
// order / checksum / length-limit settings, directed and random frames checked
// against a word-list model of the serial stream.
module tb_serial_packet_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din       [3];
    logic       din_valid [3];
    logic       rdy       [3];
    logic       dout      [3];
    logic       dv        [3];
    logic       busy      [3];
    logic       done      [3];
    logic       lerr      [3];

    int cfg_msb  [3] = '{0, 1, 0};
    int cfg_csum [3] = '{1, 1, 0};
    int cfg_max  [3] = '{255, 255, 4};

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int         lens [2];
    logic [7:0] pay  [2][16];
    int         gaps [2][16];
    logic [1:0] trace[$];

    serial_packet_tx #(.WORD_W(8), .MAX_LEN(255), .MSB_FIRST(0), .CSUM_EN(1)) dut0 (
        .tClk(clk), .Rst(rst), .Din(din[0]), .Din_Valid(din_valid[0]), .Din_Ready(rdy[0]),
        .Dout(dout[0]), .Dout_Valid(dv[0]), .Busy(busy[0]), .Done(done[0]), .Len_Err(lerr[0]));

    serial_packet_tx #(.WORD_W(8), .MAX_LEN(255), .MSB_FIRST(1), .CSUM_EN(1)) dut1 (
        .tClk(clk), .Rst(rst), .Din(din[1]), .Din_Valid(din_valid[1]), .Din_Ready(rdy[1]),
        .Dout(dout[1]), .Dout_Valid(dv[1]), .Busy(busy[1]), .Done(done[1]), .Len_Err(lerr[1]));

    serial_packet_tx #(.WORD_W(8), .MAX_LEN(4), .MSB_FIRST(0), .CSUM_EN(0)) dut2 (
        .tClk(clk), .Rst(rst), .Din(din[2]), .Din_Valid(din_valid[2]), .Din_Ready(rdy[2]),
        .Dout(dout[2]), .Dout_Valid(dv[2]), .Busy(busy[2]), .Done(done[2]), .Len_Err(lerr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one word; hold Din_Valid low for 'gap' cycles in which the DUT is ready.
    task automatic drive_word(input int d, input logic [7:0] w, input int gap, output int acc_cyc);
        int seen;
        bit taken;
        seen = 0;
        taken = 0;
        acc_cyc = -1;
        din[d] = w;
        din_valid[d] = 1'b0;
        for (int n = 0; n < 400 && !taken; n++) begin
            @(negedge clk);
            if (seen >= gap) begin
                din_valid[d] = 1'b1;
                if (rdy[d]) begin
                    @(posedge clk);
                    #1;
                    acc_cyc = cyc;
                    din_valid[d] = 1'b0;
                    taken = 1;
                end
            end else if (rdy[d]) begin
                seen++;
            end
        end
        if (!taken) begin
            din_valid[d] = 1'b0;
            chk("ready_timeout", 0, 1);
        end
    endtask

    task automatic drive_frame(input int d, input int f, output int hc);
        int c;
        drive_word(d, 8'(lens[f]), 0, hc);
        for (int k = 0; k < lens[f]; k++) drive_word(d, pay[f][k], gaps[f][k], c);
    endtask

    // Record (Dout_Valid, Dout) from the first frame bit until the Done cycle.
    task automatic collect(input int d, output int first_cyc, output int done_cyc);
        int n;
        int busy_low;
        bit fin;
        trace.delete();
        n = 0;
        busy_low = 0;
        fin = 0;
        first_cyc = -1;
        done_cyc = -1;
        @(negedge clk);
        n++;
        while (n < 3000 && !dv[d]) begin
            @(negedge clk);
            n++;
        end
        if (!dv[d]) begin
            chk("start_timeout", 0, 1);
            return;
        end
        first_cyc = cyc;
        while (n < 3000 && !fin) begin
            if (done[d]) begin
                fin = 1;
                done_cyc = cyc;
                chk("busy_in_done_cycle", 32'(busy[d]), 0);
            end else begin
                trace.push_back({dv[d], dout[d]});
                if (!busy[d]) busy_low++;
                @(negedge clk);
                n++;
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
        chk("busy_low_in_frame", busy_low, 0);
    endtask

    // Model: the frame is the word list {L, payload.., xor of all} with stall cycles
    // (valid 0, line 1) ahead of payload words that the source delayed.
    task automatic compare_frame(input int d, input int f);
        logic [7:0] words[$];
        int         wgap[$];
        logic [7:0] x;
        logic [7:0] got;
        logic [1:0] e;
        int         nv;
        int         p;
        int         exp_len;
        x = 8'(lens[f]);
        words.push_back(x);
        wgap.push_back(0);
        for (int k = 0; k < lens[f]; k++) begin
            words.push_back(pay[f][k]);
            wgap.push_back(gaps[f][k]);
            x = x ^ pay[f][k];
        end
        if (cfg_csum[d] != 0) begin
            words.push_back(x);
            wgap.push_back(0);
        end
        exp_len = 0;
        foreach (words[i]) exp_len += 8 + wgap[i];
        chk($sformatf("frame_cycles_dut%0d", d), trace.size(), exp_len);
        p = 0;
        foreach (words[i]) begin
            for (int g = 0; g < wgap[i]; g++) begin
                if (p < trace.size()) chk($sformatf("stall_cycle_w%0d", i), 32'(trace[p]), 32'h1);
                p++;
            end
            got = 8'h00;
            nv = 0;
            for (int j = 0; j < 8; j++) begin
                if (p < trace.size()) begin
                    e = trace[p];
                    nv += int'(e[1]);
                    got[(cfg_msb[d] != 0) ? 7 - j : j] = e[0];
                end
                p++;
            end
            chk($sformatf("dut%0d_word%0d_{nvalid,val}", d, i), {16'h0, nv[7:0], got}, {16'h0, 8'd8, words[i]});
        end
    endtask

    task automatic run_frame(input int d);
        int hc, fc, dc;
        fork
            drive_frame(d, 0, hc);
            collect(d, fc, dc);
        join
        compare_frame(d, 0);
        chk("hdr_accept_to_first_bit", fc - hc, 0);
        @(negedge clk);
        chk("done_single_cycle", 32'(done[d]), 0);
        chk("busy_after_frame", 32'(busy[d]), 0);
    endtask

    task automatic rand_frame(input int f, input int maxl);
        lens[f] = $urandom_range(0, maxl);
        for (int k = 0; k < 16; k++) begin
            pay[f][k] = 8'($urandom_range(0, 255));
            gaps[f][k] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        end
    endtask

    task automatic zero_gaps(input int f);
        for (int k = 0; k < 16; k++) gaps[f][k] = 0;
    endtask

    task automatic reject_test(input int d, input logic [7:0] l);
        int hc;
        drive_word(d, l, 0, hc);
        @(negedge clk);
        chk("len_err_pulse", 32'(lerr[d]), 1);
        chk("busy_on_reject", 32'(busy[d]), 0);
        chk("dout_valid_on_reject", 32'(dv[d]), 0);
        @(negedge clk);
        chk("len_err_one_cycle", 32'(lerr[d]), 0);
        chk("busy_after_reject", 32'(busy[d]), 0);
    endtask

    initial begin
        int hc1, hc2, fc1, fc2, dc1, dc2, c, dseen;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            din[d] = 8'h00;
            din_valid[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_dout", 32'(dout[d]), 1);
            chk("reset_dout_valid", 32'(dv[d]), 0);
            chk("reset_busy", 32'(busy[d]), 0);
            chk("reset_done", 32'(done[d]), 0);
            chk("reset_len_err", 32'(lerr[d]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(rdy[0]), 1);

        // Basic frame, LSB first and MSB first
        lens[0] = 2;
        pay[0][0] = 8'hA5;
        pay[0][1] = 8'h3C;
        zero_gaps(0);
        run_frame(0);
        run_frame(1);

        // Three stall cycles ahead of the second payload word
        gaps[0][1] = 3;
        run_frame(0);

        // Zero-length frames, with and without checksum
        lens[0] = 0;
        run_frame(0);
        run_frame(2);

        // Boundary: longest legal length on the small instance, then rejections
        lens[0] = 4;
        zero_gaps(0);
        for (int k = 0; k < 4; k++) pay[0][k] = 8'($urandom_range(0, 255));
        run_frame(2);
        reject_test(2, 8'h05);
        reject_test(2, 8'hFF);

        // Back-to-back frames: second header taken in the Done cycle
        rand_frame(0, 3);
        rand_frame(1, 3);
        zero_gaps(0);
        zero_gaps(1);
        fork
            begin
                drive_frame(0, 0, hc1);
                drive_frame(0, 1, hc2);
            end
            begin
                collect(0, fc1, dc1);
                compare_frame(0, 0);
                collect(0, fc2, dc2);
                compare_frame(0, 1);
            end
        join
        chk("b2b_hdr_accept_after_done", hc2 - dc1, 1);
        chk("b2b_first_bit_after_done", fc2 - dc1, 1);
        @(negedge clk);

        // Reset during bit 3 of the first payload word
        drive_word(0, 8'd3, 0, c);
        drive_word(0, 8'hA5, 0, c);
        repeat (4) @(negedge clk);
        chk("pre_reset_dout_valid", 32'(dv[0]), 1);
        chk("pre_reset_bit3", 32'(dout[0]), 0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_dout", 32'(dout[0]), 1);
        chk("async_reset_dout_valid", 32'(dv[0]), 0);
        chk("async_reset_busy", 32'(busy[0]), 0);
        dseen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done[0]) dseen++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done[0]) dseen++;
        end
        chk("no_done_after_reset", dseen, 0);
        rand_frame(0, 5);
        run_frame(0);

        // Random frames on random instances, with occasional rejected headers
        for (int it = 0; it < 30; it++) begin
            int d;
            d = $urandom_range(0, 2);
            if (d == 2 && $urandom_range(0, 3) == 0) begin
                reject_test(2, 8'($urandom_range(cfg_max[2] + 1, 255)));
            end else begin
                rand_frame(0, (d == 2) ? cfg_max[2] : 8);
                run_frame(d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
